// File: rtl/addsub_if.sv
// Handshake and operand/result bundle for addsub_pipe.
// master drives operations and out_ready; slave is the arithmetic unit.
interface addsub_if #(
  parameter int NUM = 32
) ();
  logic           in_valid;
  logic           in_ready;
  logic [NUM-1:0] a;
  logic [NUM-1:0] b;
  logic           op_sub;
  logic           sign;
  logic           sat;
  logic           out_valid;
  logic           out_ready;
  logic [NUM-1:0] s;
  logic           carry;
  logic           overflow;
  logic           zero;

  modport master (
    output in_valid, a, b, op_sub, sign, sat, out_ready,
    input  in_ready, out_valid, s, carry, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, op_sub, sign, sat, out_ready,
    output in_ready, out_valid, s, carry, overflow, zero
  );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract with carry/overflow/zero flags and valid/ready flow control.
// Define ADDSUB_SAT_EN to build the saturation mux driven by the sat input.
module addsub_pipe #(
  parameter int NUM    = 32,
  parameter int STAGES = 2
) (
  input logic     clk,
  input logic     rst_n,
  addsub_if.slave bus
);

  function automatic logic ovf_f(input logic sgn_m, input logic sub_m, input logic co,
                                 input logic a_msb, input logic bb_msb, input logic r_msb);
    if (sgn_m) return (a_msb == bb_msb) && (r_msb != a_msb);
    return sub_m ? ~co : co;
  endfunction

`ifdef ADDSUB_SAT_EN
  function automatic logic [NUM-1:0] sat_f(input logic sgn_m, input logic sub_m,
                                           input logic a_msb);
    if (sgn_m) return a_msb ? {1'b1, {(NUM-1){1'b0}}} : {1'b0, {(NUM-1){1'b1}}};
    return sub_m ? {NUM{1'b0}} : {NUM{1'b1}};
  endfunction
`else
  logic unused_sat;
  assign unused_sat = bus.sat;
`endif

  logic [NUM-1:0] bb_c;
  logic [NUM-1:0] r_c;
  logic [NUM-1:0] res_c;
  logic [NUM:0]   sum_c;
  logic           co_c;
  logic           ovf_c;

  // ---- combinational arithmetic feeding stage 0 ----
  always_comb begin
    bb_c  = bus.op_sub ? ~bus.b : bus.b;
    sum_c = {1'b0, bus.a} + {1'b0, bb_c} + {{NUM{1'b0}}, bus.op_sub};
    r_c   = sum_c[NUM-1:0];
    co_c  = sum_c[NUM];
    ovf_c = ovf_f(bus.sign, bus.op_sub, co_c, bus.a[NUM-1], bb_c[NUM-1], r_c[NUM-1]);
`ifdef ADDSUB_SAT_EN
    res_c = (bus.sat && ovf_c) ? sat_f(bus.sign, bus.op_sub, bus.a[NUM-1]) : r_c;
`else
    res_c = r_c;
`endif
  end

  logic [STAGES-1:0] vld_p;
  logic [STAGES-1:0] go_p;
  logic              in_rdy;
  logic              nxt;

  // go_p[k]: slot k may take new content (its successor is empty or moving on)
  always_comb begin
    go_p = '0;
    nxt  = bus.out_ready;
    for (int k = STAGES-1; k >= 0; k--) begin
      go_p[k] = nxt;
      nxt     = ~vld_p[k] | nxt;
    end
    in_rdy = nxt;
  end

  logic [NUM-1:0]    s_p [STAGES];
  logic [STAGES-1:0] c_p;
  logic [STAGES-1:0] o_p;
  logic [STAGES-1:0] z_p;

  // ---- stage 0 capture, stages 1..STAGES-1 delay only ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
      c_p   <= '0;
      o_p   <= '0;
      z_p   <= '0;
      for (int k = 0; k < STAGES; k++) s_p[k] <= '0;
    end else begin
      if (in_rdy) begin
        vld_p[0] <= bus.in_valid;
        if (bus.in_valid) begin
          s_p[0] <= res_c;
          c_p[0] <= co_c;
          o_p[0] <= ovf_c;
          z_p[0] <= (res_c == '0);
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (~vld_p[k] | go_p[k]) begin
          vld_p[k] <= vld_p[k-1];
          if (vld_p[k-1]) begin
            s_p[k] <= s_p[k-1];
            c_p[k] <= c_p[k-1];
            o_p[k] <= o_p[k-1];
            z_p[k] <= z_p[k-1];
          end
        end
      end
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = vld_p[STAGES-1];
  assign bus.s         = s_p[STAGES-1];
  assign bus.carry     = c_p[STAGES-1];
  assign bus.overflow  = o_p[STAGES-1];
  assign bus.zero      = z_p[STAGES-1];

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed testbench for addsub_pipe: vector table plus flow-control and reset sequences.
// Expected sums follow the build: define ADDSUB_SAT_EN here as well as for the RTL.
module tb_addsub_pipe;
  localparam int NUM    = 32;
  localparam int STAGES = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addsub_if #(.NUM(NUM)) bus ();

  addsub_pipe #(.NUM(NUM), .STAGES(STAGES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        sgn;
    logic        sat;
    logic [31:0] s_w;
    logic        z_w;
    logic [31:0] s_s;
    logic        z_s;
    logic        c;
    logic        o;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkint(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_op(input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic sgn, input logic sat);
    bus.a      = a;
    bus.b      = b;
    bus.op_sub = sub;
    bus.sign   = sgn;
    bus.sat    = sat;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] es;
    logic        ez;
    int          lat;
    string       tag;
`ifdef ADDSUB_SAT_EN
    es = v.sat ? v.s_s : v.s_w;
    ez = v.sat ? v.z_s : v.z_w;
`else
    es = v.s_w;
    ez = v.z_w;
`endif
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    drive_op(v.a, v.b, v.sub, v.sgn, v.sat);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chkint({tag, "_latency"}, lat, STAGES-1);
    chk32({tag, "_s"}, bus.s, es);
    chk1({tag, "_carry"}, bus.carry, v.c);
    chk1({tag, "_overflow"}, bus.overflow, v.o);
    chk1({tag, "_zero"}, bus.zero, ez);
  endtask

  vec_t        vt [13];
  logic [31:0] exp_q [$];
  logic [31:0] exp_d [2];
  int          first, last, rx, acc, vcnt;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //             a             b             sub   sgn   sat   s_w           z_w   s_s           z_s   c     o
    vt[0]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 1'b0, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1};
    vt[1]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 1'b1, 32'h80000000, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1};
    vt[2]  = '{32'h00000003, 32'h00000005, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1};
    vt[3]  = '{32'h00000003, 32'h00000005, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vt[4]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b1};
    vt[5]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vt[6]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1};
    vt[7]  = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b1};
    vt[8]  = '{32'h00000005, 32'h00000005, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vt[9]  = '{32'h00000005, 32'hFFFFFFFD, 1'b0, 1'b1, 1'b0, 32'h00000002, 1'b0, 32'h00000002, 1'b0, 1'b1, 1'b0};
    vt[10] = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 1'b0, 32'h23456789, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0};
    vt[11] = '{32'h00000000, 32'h00000001, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vt[12] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 32'h80000000, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive_op(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // reset state
    repeat (2) @(negedge clk);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk32("rst_s", bus.s, 32'h0);
    chk1("rst_carry", bus.carry, 1'b0);
    chk1("rst_overflow", bus.overflow, 1'b0);
    chk1("rst_zero", bus.zero, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("rst_in_ready", bus.in_ready, 1'b1);

    for (int i = 0; i < 13; i++) run_vec(vt[i], i);

    // back-to-back stream with out_ready held high
    repeat (2) @(negedge clk);
    first = -1; last = -1; rx = 0; acc = 0;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 8 + STAGES + 2; n++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (first < 0) first = n;
        last = n;
        if (rx < exp_q.size()) chk32("stream_s", bus.s, exp_q[rx]);
        else chk32("stream_extra", bus.s, 32'hDEADBEEF);
        rx++;
      end
      if (n < 8) begin
        drive_op(32'h10 * n + 1, n, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(32'h10 * n + 1 + n);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (bus.in_valid && bus.in_ready) acc++;
    end
    chkint("stream_accepts", acc, 8);
    chkint("stream_results", rx, 8);
    chkint("stream_first_cycle", first, STAGES);
    chkint("stream_span", last - first + 1, 8);

    // backpressure: out_ready low for 5 cycles
    acc = 0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive_op(32'h100 + k, 32'h0, 1'b0, 1'b0, 1'b0);
      bus.in_valid = 1'b1;
      #1;
      if (bus.in_ready) acc++;
      if (bus.out_valid) chk32("hold_s", bus.s, 32'h100);
    end
    chkint("hold_accepts", acc, STAGES);
    chk1("hold_in_ready", bus.in_ready, 1'b0);

    // full pipe: simultaneous out and in transfers
    @(negedge clk);
    drive_op(32'h200, 32'h0, 1'b0, 1'b0, 1'b0);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk1("full_in_ready", bus.in_ready, 1'b1);
    chk32("full_out_s", bus.s, 32'h100);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk1("full_still_full", bus.in_ready, 1'b0);
    chk1("full_out_valid", bus.out_valid, 1'b1);
    chk32("full_next_s", bus.s, 32'h101);
    exp_d[0] = 32'h101;
    exp_d[1] = 32'h200;
    rx = 0;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      if (n > 0) @(negedge clk);
      if (bus.out_valid) begin
        if (rx < 2) chk32("drain_s", bus.s, exp_d[rx]);
        else chk32("drain_extra", bus.s, 32'hDEADBEEF);
        rx++;
      end
    end
    chkint("drain_count", rx, 2);

    // reset with two operations in flight
    @(negedge clk);
    drive_op(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    @(negedge clk);
    drive_op(32'h55, 32'h22, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk1("mid_pre_valid", bus.out_valid, 1'b1);
    chk1("mid_pre_zero", bus.zero, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_valid", bus.out_valid, 1'b0);
    chk32("mid_rst_s", bus.s, 32'h0);
    chk1("mid_rst_carry", bus.carry, 1'b0);
    chk1("mid_rst_overflow", bus.overflow, 1'b0);
    chk1("mid_rst_zero", bus.zero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    vcnt = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (bus.out_valid) vcnt++;
    end
    chkint("mid_no_stale", vcnt, 0);
    chk1("mid_in_ready", bus.in_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
